pkt_dispatch: RTL
=================

// Module: pkt_dispatch
// PURPOSE
//  Upstream stage of the action executor. Accepts a packet base address and parses the L2 header in shared memory.
//  Parses Ethernet with optional single 802.1Q tag, locates IPv4, fetches the action-table entry and drives the executor start handshake.
//  Owns the memory port only while parsing; the top-level mux gives memory to the executor while ex_start_o is high.
// PARAMETERS
//  ACT_TBL_BASE  32'h0000_0100  byte address of action table; entry i = {start_addr, args_start} at base+8*i
//  ETYPE_IPV4    16'h0800       EtherType selecting table entry 1
//  ETYPE_VLAN    16'h8100       EtherType of one 4-byte VLAN tag to skip
//  EX_TIMEOUT    1024           max cycles to wait for ex_done_i before abort
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  pkt_start_i    in   1   request: parse packet at pkt_addr_i (sampled in IDLE only)
//  pkt_addr_i     in   32  packet byte base address
//  pkt_busy_o     out  1   high from accept until pkt_done_o
//  pkt_done_o     out  1   one-cycle completion pulse
//  pkt_err_o      out  1   valid with pkt_done_o: 1 = executor timeout
//  mem_ce_o       out  1   memory enable
//  mem_we_o       out  1   always 0 (read-only block)
//  mem_addr_o     out  32  byte address
//  mem_width_o    out  4   access width in bytes (2 or 4)
//  mem_data_o     out  32  always 0
//  mem_data_i     in   32  read data, same cycle as address, big-endian, right-aligned
//  ex_start_o     out  1   executor start, level
//  ex_start_addr_o out 32  action program start address
//  ex_args_start_o out 32  action argument block address
//  ex_hdrs_o      out  64  [63:32] = hdr0 (L2 start), [31:0] = hdr1 (IPv4 start or 32'hFFFF_FFFF)
//  ex_done_i      in   1   executor ready/done level
// BEHAVIOUR
//  Reset (async) puts the FSM in IDLE and clears base, hdr registers, ex_* outputs, counters, pkt_* and mem_* to 0; ex_hdrs_o resets to 0.
//  Reset mid-operation aborts immediately: no done pulse; ex_start_o drops in the same cycle.
//  FSM states and transitions:
//  IDLE: pkt_start_i=1 latches base <= pkt_addr_i and hdr0 <= pkt_addr_i -> RD_ETYPE. Otherwise hold; mem_ce_o=0.
//  RD_ETYPE: ce=1, width=2, addr=base+12+4*vlan. Data = etype in [15:0], [31:16]=0.
//   etype==ETYPE_VLAN && !vlan: set vlan=1 and stay in RD_ETYPE (one tag only).
//   etype==ETYPE_IPV4: hdr1 = base+14+4*vlan, idx = 1.
//   Any other etype, including a second VLAN tag: hdr1 = 32'hFFFF_FFFF, idx = 0.
//   Both non-VLAN outcomes -> RD_ENT0.
//  RD_ENT0: ce=1, width=4, addr=ACT_TBL_BASE+8*idx; start_addr <= data -> RD_ENT1.
//  RD_ENT1: addr+4; args_start <= data -> DISPATCH.
//  DISPATCH: mem_ce_o=0, ex_start_o=1. ex_* outputs stay stable for the whole state. A 3-cycle guard ignores ex_done_i,
//   because the executor minimum latency is 3 and its done is level/sticky.
//   After the guard, ex_done_i=1 -> DONE with err=0. The timeout counter reaching EX_TIMEOUT-1 -> DONE with err=1.
//  DONE: ex_start_o=0, pkt_done_o=1 for one cycle, pkt_err_o=err -> IDLE.
//  Latency, accept to ex_start_o rise: 3 cycles without VLAN, 4 with VLAN.
//  pkt_start_i while busy is ignored; it is not queued.
//  All address arithmetic is 32-bit modulo 2^32; wrap-around is legal and not flagged.
//  pkt_busy_o = (state != IDLE).
// STRUCTURE
//  def.vh gains PD_STATE_* codes (3-bit bus PD_STATE_BUS), HDR_INVALID = 32'hFFFF_FFFF and PD_TIMEOUT_BUS.
//  One natural sub-module, pd_timeout: a loadable down-counter with an expire flag, reused by later stages.
//  Everything else stays in one sequential always block plus combinational mem/ex output assigns.
// TESTING
//  1. base 0x40, etype 0x0800 at 0x4C, table[1]={0x200,0x300}, ex_done after 10 cycles:
//     hdrs={0x40,0x4E}, start=0x200, args=0x300, ex_start rises 3 cycles after accept, done pulse err=0.
//  2. etype 0x8100 then 0x0800 at 0x50: hdr1=0x52, table[1] used, 4-cycle start latency.
//  3. etype 0x86DD: hdr1=0xFFFF_FFFF, table[0] read at 0x100/0x104.
//  4. ex_done_i held high from before start (sticky): no completion before guard expires; completes on cycle 4 of DISPATCH.
//  5. ex_done_i never asserted, EX_TIMEOUT=16: done pulse with err=1 exactly 16 cycles after ex_start rise.
//  6. rst asserted in RD_ENT0 and in DISPATCH: all outputs 0 asynchronously, no done pulse; a new packet after release parses correctly.
//  Also: pkt_start_i pulsed while busy is ignored; base 0xFFFF_FFF8 wraps etype addr to 0x4.

Source files
------------

// File: rtl/pkt_dispatch_pkg.sv
// Shared constants for the packet dispatcher: FSM state codes, the invalid-header
// sentinel and sizing of the executor timeout counter.
package pkt_dispatch_pkg;

  localparam int PD_STATE_BUS = 3;

  localparam logic [PD_STATE_BUS-1:0] PD_STATE_IDLE     = 3'd0;
  localparam logic [PD_STATE_BUS-1:0] PD_STATE_RD_ETYPE = 3'd1;
  localparam logic [PD_STATE_BUS-1:0] PD_STATE_RD_ENT0  = 3'd2;
  localparam logic [PD_STATE_BUS-1:0] PD_STATE_RD_ENT1  = 3'd3;
  localparam logic [PD_STATE_BUS-1:0] PD_STATE_DISPATCH = 3'd4;
  localparam logic [PD_STATE_BUS-1:0] PD_STATE_DONE     = 3'd5;

  localparam logic [31:0] HDR_INVALID = 32'hFFFF_FFFF;

  // Executor minimum latency is 3 cycles; its done flag is ignored until the guard reaches this value.
  localparam logic [1:0] PD_GUARD_LAST = 2'd3;

  // Width of a down-counter that must hold timeout-1.
  function automatic int pd_timeout_bus(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/pkt_dispatch_timeout.sv
// Loadable down-counter with an expire flag; stops at zero and stays expired until reloaded.
module pkt_dispatch_timeout #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/pkt_dispatch.sv
// Packet dispatcher: parses the L2 header (optional single VLAN tag), fetches the
// action-table entry for the packet class and holds the executor start handshake.
module pkt_dispatch
  import pkt_dispatch_pkg::*;
#(
  parameter logic [31:0] ACT_TBL_BASE = 32'h0000_0100,
  parameter logic [15:0] ETYPE_IPV4   = 16'h0800,
  parameter logic [15:0] ETYPE_VLAN   = 16'h8100,
  parameter int          EX_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_start_i,
  input  logic [31:0] pkt_addr_i,
  output logic        pkt_busy_o,
  output logic        pkt_done_o,
  output logic        pkt_err_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_width_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        ex_start_o,
  output logic [31:0] ex_start_addr_o,
  output logic [31:0] ex_args_start_o,
  output logic [63:0] ex_hdrs_o,
  input  logic        ex_done_i
);

  localparam int PD_TIMEOUT_BUS = pd_timeout_bus(EX_TIMEOUT);
  localparam logic [PD_TIMEOUT_BUS-1:0] TIMEOUT_LOAD = PD_TIMEOUT_BUS'(EX_TIMEOUT - 1);

  logic [PD_STATE_BUS-1:0] state_q, state_d;
  logic [31:0] base_q, hdr0_q, hdr1_q, start_addr_q, args_start_q;
  logic        vlan_q, idx_q, err_q;
  logic [1:0]  guard_q;

  logic [15:0] etype;
  logic [31:0] vlan_off, ent_addr;
  logic        guard_done, to_expired, is_vlan_tag;

  assign etype       = mem_data_i[15:0];
  assign vlan_off    = {29'd0, vlan_q, 2'b00};
  assign ent_addr    = ACT_TBL_BASE + {28'd0, idx_q, 3'b000};
  assign guard_done  = (guard_q == PD_GUARD_LAST);
  assign is_vlan_tag = (etype == ETYPE_VLAN) && !vlan_q;

  pkt_dispatch_timeout #(.W(PD_TIMEOUT_BUS)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == PD_STATE_RD_ENT1),
    .load_val_i (TIMEOUT_LOAD),
    .en_i       (state_q == PD_STATE_DISPATCH),
    .expired_o  (to_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PD_STATE_IDLE:     if (pkt_start_i) state_d = PD_STATE_RD_ETYPE;
      PD_STATE_RD_ETYPE: if (!is_vlan_tag) state_d = PD_STATE_RD_ENT0;
      PD_STATE_RD_ENT0:  state_d = PD_STATE_RD_ENT1;
      PD_STATE_RD_ENT1:  state_d = PD_STATE_DISPATCH;
      PD_STATE_DISPATCH: if ((guard_done && ex_done_i) || to_expired) state_d = PD_STATE_DONE;
      PD_STATE_DONE:     state_d = PD_STATE_IDLE;
      default:           state_d = PD_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PD_STATE_IDLE;
      base_q       <= '0;
      hdr0_q       <= '0;
      hdr1_q       <= '0;
      start_addr_q <= '0;
      args_start_q <= '0;
      vlan_q       <= 1'b0;
      idx_q        <= 1'b0;
      err_q        <= 1'b0;
      guard_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        PD_STATE_IDLE: begin
          if (pkt_start_i) begin
            base_q <= pkt_addr_i;
            hdr0_q <= pkt_addr_i;
            vlan_q <= 1'b0;
            idx_q  <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        PD_STATE_RD_ETYPE: begin
          if (is_vlan_tag) begin
            vlan_q <= 1'b1;
          end else if (etype == ETYPE_IPV4) begin
            hdr1_q <= base_q + 32'd14 + vlan_off;
            idx_q  <= 1'b1;
          end else begin
            hdr1_q <= HDR_INVALID;
            idx_q  <= 1'b0;
          end
        end
        PD_STATE_RD_ENT0: start_addr_q <= mem_data_i;
        PD_STATE_RD_ENT1: begin
          args_start_q <= mem_data_i;
          guard_q      <= '0;
        end
        PD_STATE_DISPATCH: begin
          if (!guard_done) guard_q <= guard_q + 2'd1;
          // A done seen after the guard wins over a simultaneous timeout.
          if (state_d == PD_STATE_DONE) err_q <= !(guard_done && ex_done_i);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_width_o = 4'd0;
    mem_addr_o  = 32'd0;
    case (state_q)
      PD_STATE_RD_ETYPE: begin
        mem_ce_o    = 1'b1;
        mem_width_o = 4'd2;
        mem_addr_o  = base_q + 32'd12 + vlan_off;
      end
      PD_STATE_RD_ENT0: begin
        mem_ce_o    = 1'b1;
        mem_width_o = 4'd4;
        mem_addr_o  = ent_addr;
      end
      PD_STATE_RD_ENT1: begin
        mem_ce_o    = 1'b1;
        mem_width_o = 4'd4;
        mem_addr_o  = ent_addr + 32'd4;
      end
      default: ;
    endcase
  end

  assign mem_we_o        = 1'b0;
  assign mem_data_o      = 32'd0;
  assign pkt_busy_o      = (state_q != PD_STATE_IDLE);
  assign pkt_done_o      = (state_q == PD_STATE_DONE);
  assign pkt_err_o       = pkt_done_o && err_q;
  assign ex_start_o      = (state_q == PD_STATE_DISPATCH);
  assign ex_start_addr_o = start_addr_q;
  assign ex_args_start_o = args_start_q;
  assign ex_hdrs_o       = {hdr0_q, hdr1_q};

endmodule
